// File: rtl/serdesphy_ana_bias_monitor.sv
// ----------------------------------------------------------------------------
// serdesphy_ana_bias_monitor
//
// Sequences power-up of the SerDes PHY analog bias generator and supervises
// the bias status lines.
//
// On a power request it enables the bias generator (RAMP) and waits for the
// tx, rx and vco biases and bias_ready. It then requires them to stay high
// for SETTLE_CYC cycles (SETTLE) before it raises the downstream analog
// enables and pwr_ack (ON).
//
// A timeout, an out-of-order bias, or a bias dropping out latches a fault
// code (FAULT). The fault is released only by fault_clr while pwr_req is low.
// Shutdown (iso_en or !pwr_req) always beats a fault detected in the same
// cycle.
//
// Ports:
//   clk                         system clock
//   rst_n                       synchronous active-low reset
//   pwr_req                     level request to power the analog domains
//   iso_en                      analog isolation, forces orderly shutdown
//   tx_bias, rx_bias, vco_bias  bias-good status from the generator
//   bias_ready                  generator ready status
//   fault_clr                   releases a latched fault (needs pwr_req=0)
//   bias_en                     enable to the bias generator
//   tx_ana_en, rx_ana_en,
//   pll_ana_en                  downstream analog enables
//   pwr_ack                     power-good acknowledge
//   bias_fault                  fault latched
//   fault_code                  0 none, 1 timeout, 2 order, 3 dropout
//   fault_count                 saturating count of FAULT entries
//   state                       current FSM state
// ----------------------------------------------------------------------------
module serdesphy_ana_bias_monitor #(
    parameter int TIMEOUT_CYC = 160,
    parameter int SETTLE_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       iso_en,
    input  logic       tx_bias,
    input  logic       rx_bias,
    input  logic       vco_bias,
    input  logic       bias_ready,
    input  logic       fault_clr,
    output logic       bias_en,
    output logic       tx_ana_en,
    output logic       rx_ana_en,
    output logic       pll_ana_en,
    output logic       pwr_ack,
    output logic       bias_fault,
    output logic [1:0] fault_code,
    output logic [7:0] fault_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_ORDER   = 2'd2;
    localparam logic [1:0] CODE_DROPOUT = 2'd3;

    // Last counter value before the timeout / settle condition fires.
    localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_t     state_r;
    state_t     next_s;
    logic [7:0] timer_r;
    logic [7:0] settle_r;
    logic [1:0] code_s;
    logic [1:0] fault_code_r;
    logic [7:0] fault_count_r;
    logic       bias_en_r;
    logic       ana_en_r;
    logic       bias_fault_r;
    logic       shutdown_s;
    logic       all_up_s;
    logic       order_bad_s;

    // Next-state logic and fault classification.
    always_comb begin
        next_s      = state_r;
        code_s      = CODE_NONE;
        shutdown_s  = iso_en | ~pwr_req;
        all_up_s    = bias_ready & tx_bias & rx_bias & vco_bias;
        order_bad_s = (rx_bias & ~tx_bias) | (vco_bias & ~rx_bias);
        case (state_r)
            ST_OFF: begin
                if (pwr_req && !iso_en) begin
                    next_s = ST_RAMP;
                end else begin
                    next_s = ST_OFF;
                end
            end
            ST_RAMP: begin
                if (shutdown_s) begin
                    next_s = ST_OFF;
                end else if (order_bad_s) begin
                    next_s = ST_FAULT;
                    code_s = CODE_ORDER;
                end else if (timer_r == TIMER_LAST) begin
                    next_s = ST_FAULT;
                    code_s = CODE_TIMEOUT;
                end else if (all_up_s) begin
                    next_s = ST_SETTLE;
                end else begin
                    next_s = ST_RAMP;
                end
            end
            // Once ramped, any order violation necessarily has a bias low,
            // so it is reported as a dropout.
            ST_SETTLE: begin
                if (shutdown_s) begin
                    next_s = ST_OFF;
                end else if (!all_up_s) begin
                    next_s = ST_FAULT;
                    code_s = CODE_DROPOUT;
                end else if (settle_r == SETTLE_LAST) begin
                    next_s = ST_ON;
                end else begin
                    next_s = ST_SETTLE;
                end
            end
            ST_ON: begin
                if (shutdown_s) begin
                    next_s = ST_OFF;
                end else if (!all_up_s) begin
                    next_s = ST_FAULT;
                    code_s = CODE_DROPOUT;
                end else begin
                    next_s = ST_ON;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !pwr_req) begin
                    next_s = ST_OFF;
                end else begin
                    next_s = ST_FAULT;
                end
            end
            default: begin
                next_s = ST_OFF;
            end
        endcase
    end

    // State, counters, fault bookkeeping and registered output decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_OFF;
            timer_r       <= 8'd0;
            settle_r      <= 8'd0;
            fault_code_r  <= CODE_NONE;
            fault_count_r <= 8'd0;
            bias_en_r     <= 1'b0;
            ana_en_r      <= 1'b0;
            bias_fault_r  <= 1'b0;
        end else begin
            state_r <= next_s;

            // Timer counts only while staying in RAMP and restarts on entry.
            if (next_s == ST_RAMP && state_r != ST_RAMP) begin
                timer_r <= 8'd0;
            end else if (next_s == ST_RAMP) begin
                timer_r <= timer_r + 8'd1;
            end else begin
                timer_r <= timer_r;
            end

            if (next_s == ST_SETTLE && state_r != ST_SETTLE) begin
                settle_r <= 8'd0;
            end else if (next_s == ST_SETTLE) begin
                settle_r <= settle_r + 8'd1;
            end else begin
                settle_r <= settle_r;
            end

            // Code is captured on FAULT entry, held while in FAULT, zero elsewhere.
            if (next_s == ST_FAULT && state_r != ST_FAULT) begin
                fault_code_r <= code_s;
                if (fault_count_r != 8'd255) begin
                    fault_count_r <= fault_count_r + 8'd1;
                end else begin
                    fault_count_r <= fault_count_r;
                end
            end else if (next_s == ST_FAULT) begin
                fault_code_r <= fault_code_r;
            end else begin
                fault_code_r <= CODE_NONE;
            end

            // Outputs are decoded from the state being entered so they track state_r.
            bias_en_r    <= (next_s == ST_RAMP) || (next_s == ST_SETTLE) || (next_s == ST_ON);
            ana_en_r     <= (next_s == ST_ON);
            bias_fault_r <= (next_s == ST_FAULT);
        end
    end

    assign state       = state_r;
    assign bias_en     = bias_en_r;
    assign tx_ana_en   = ana_en_r;
    assign rx_ana_en   = ana_en_r;
    assign pll_ana_en  = ana_en_r;
    assign pwr_ack     = ana_en_r;
    assign bias_fault  = bias_fault_r;
    assign fault_code  = fault_code_r;
    assign fault_count = fault_count_r;

endmodule

// File: tb/tb_serdesphy_ana_bias_monitor.sv
// ----------------------------------------------------------------------------
// Testbench for serdesphy_ana_bias_monitor: directed power-up / fault
// scenarios followed by randomized traffic. Every cycle the full output set
// is compared against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_serdesphy_ana_bias_monitor;

    localparam int TIMEOUT = 160;
    localparam int SETTLE  = 4;

    localparam int M_OFF    = 0;
    localparam int M_RAMP   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_ON     = 3;
    localparam int M_FAULT  = 4;

    logic       clk = 1'b0;
    logic       rst_n, pwr_req, iso_en, tx_bias, rx_bias, vco_bias, bias_ready, fault_clr;
    logic       bias_en, tx_ana_en, rx_ana_en, pll_ana_en, pwr_ack, bias_fault;
    logic [1:0] fault_code;
    logic [7:0] fault_count;
    logic [2:0] state;
    logic [18:0] outs;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_state = M_OFF;
    int m_ramp_cycles = 0;
    int m_settle_cycles = 0;
    int m_code = 0;
    int m_count = 0;

    serdesphy_ana_bias_monitor #(
        .TIMEOUT_CYC(TIMEOUT),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwr_req    (pwr_req),
        .iso_en     (iso_en),
        .tx_bias    (tx_bias),
        .rx_bias    (rx_bias),
        .vco_bias   (vco_bias),
        .bias_ready (bias_ready),
        .fault_clr  (fault_clr),
        .bias_en    (bias_en),
        .tx_ana_en  (tx_ana_en),
        .rx_ana_en  (rx_ana_en),
        .pll_ana_en (pll_ana_en),
        .pwr_ack    (pwr_ack),
        .bias_fault (bias_fault),
        .fault_code (fault_code),
        .fault_count(fault_count),
        .state      (state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    assign outs = {state, bias_en, tx_ana_en, rx_ana_en, pll_ana_en, pwr_ack,
                   bias_fault, fault_code, fault_count};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: advance by one clock edge given the current inputs.
    task automatic model_step();
        int  nxt;
        int  code;
        bit  shut, all_up, order_bad;
        if (!rst_n) begin
            m_state = M_OFF; m_ramp_cycles = 0; m_settle_cycles = 0;
            m_code = 0; m_count = 0;
            return;
        end
        shut      = iso_en || !pwr_req;
        all_up    = tx_bias && rx_bias && vco_bias && bias_ready;
        order_bad = (rx_bias && !tx_bias) || (vco_bias && !rx_bias);
        nxt  = m_state;
        code = 0;
        if (m_state == M_OFF) begin
            if (pwr_req && !iso_en) nxt = M_RAMP;
        end else if (m_state == M_RAMP) begin
            m_ramp_cycles = m_ramp_cycles + 1;
            if (shut) nxt = M_OFF;
            else if (order_bad) begin nxt = M_FAULT; code = 2; end
            else if (m_ramp_cycles == TIMEOUT) begin nxt = M_FAULT; code = 1; end
            else if (all_up) nxt = M_SETTLE;
        end else if (m_state == M_SETTLE) begin
            m_settle_cycles = m_settle_cycles + 1;
            if (shut) nxt = M_OFF;
            else if (!all_up) begin nxt = M_FAULT; code = 3; end
            else if (m_settle_cycles == SETTLE) nxt = M_ON;
        end else if (m_state == M_ON) begin
            if (shut) nxt = M_OFF;
            else if (!all_up) begin nxt = M_FAULT; code = 3; end
        end else begin
            if (fault_clr && !pwr_req) nxt = M_OFF;
        end
        if (nxt == M_RAMP && m_state != M_RAMP) m_ramp_cycles = 0;
        if (nxt == M_SETTLE && m_state != M_SETTLE) m_settle_cycles = 0;
        if (nxt == M_FAULT && m_state != M_FAULT) begin
            m_code  = code;
            m_count = (m_count < 255) ? m_count + 1 : 255;
        end
        if (nxt != M_FAULT) m_code = 0;
        m_state = nxt;
    endtask

    function automatic logic [18:0] model_vec();
        logic on, pw;
        on = (m_state == M_ON);
        pw = (m_state == M_RAMP) || (m_state == M_SETTLE) || on;
        return {3'(m_state), pw, on, on, on, on, (m_state == M_FAULT), 2'(m_code), 8'(m_count)};
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag, 32'(outs), 32'(model_vec()));
    endtask

    task automatic set_bias(input logic t, input logic r, input logic v, input logic rdy);
        tx_bias = t; rx_bias = r; vco_bias = v; bias_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pwr_req = 1'b0; iso_en = 1'b0; fault_clr = 1'b0;
        set_bias(1'b0, 1'b0, 1'b0, 1'b0);
        tick("reset_cycle");
        check("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
    endtask

    // Bias generator: tx@1, rx@33, vco@65, ready@97 cycles after pwr_req rises.
    task automatic ramp_up(input int n);
        for (int k = 0; k < n; k++) begin
            pwr_req = 1'b1; iso_en = 1'b0; fault_clr = 1'b0;
            set_bias(k >= 1, k >= 33, k >= 65, k >= 97);
            tick("ramp_up");
            if (k == 0)   check("enter_ramp", 32'(state), 32'd1);
            if (k == 96)  check("still_ramp", 32'(state), 32'd1);
            if (k == 97)  check("enter_settle", 32'(state), 32'd2);
            if (k == 100) check("settle_hold", 32'(state), 32'd2);
            if (k == 101) begin
                check("enter_on", 32'(state), 32'd3);
                check("on_pwr_ack", 32'(pwr_ack), 32'd1);
                check("on_enables", 32'({bias_en, tx_ana_en, rx_ana_en, pll_ana_en}), 32'hF);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; pwr_req = 1'b0; iso_en = 1'b0; fault_clr = 1'b0;
        set_bias(1'b0, 1'b0, 1'b0, 1'b0);

        // Normal power-up to ON
        do_reset();
        ramp_up(102);
        for (int i = 0; i < 5; i++) tick("on_steady");

        // Timeout: bias_ready never asserts
        do_reset();
        pwr_req = 1'b1;
        for (int k = 0; k <= TIMEOUT; k++) begin
            tick("timeout_run");
            if (k == TIMEOUT - 1) check("pre_timeout_state", 32'(state), 32'd1);
        end
        check("timeout_state", 32'(state), 32'd4);
        check("timeout_code", 32'(fault_code), 32'd1);
        check("timeout_bias_en", 32'(bias_en), 32'd0);
        check("timeout_count", 32'(fault_count), 32'd1);

        // Dropout in ON, fault_clr gated by pwr_req
        do_reset();
        ramp_up(102);
        rx_bias = 1'b0;
        tick("dropout");
        check("dropout_state", 32'(state), 32'd4);
        check("dropout_code", 32'(fault_code), 32'd3);
        rx_bias = 1'b1; fault_clr = 1'b1;
        for (int i = 0; i < 3; i++) tick("clr_ignored");
        check("clr_ignored_state", 32'(state), 32'd4);
        pwr_req = 1'b0;
        tick("clr_exit");
        fault_clr = 1'b0;
        check("clr_exit_state", 32'(state), 32'd0);
        check("clr_exit_code", 32'(fault_code), 32'd0);
        check("clr_exit_count", 32'(fault_count), 32'd1);

        // Order violation in RAMP
        do_reset();
        pwr_req = 1'b1;
        tick("order_enter");
        set_bias(1'b1, 1'b0, 1'b1, 1'b0);
        tick("order_viol");
        check("order_state", 32'(state), 32'd4);
        check("order_code", 32'(fault_code), 32'd2);

        // Shutdown beats dropout in SETTLE
        do_reset();
        ramp_up(98);
        iso_en = 1'b1; bias_ready = 1'b0;
        tick("iso_vs_drop");
        check("iso_state", 32'(state), 32'd0);
        check("iso_no_fault", 32'({bias_fault, fault_code}), 32'd0);
        check("iso_count", 32'(fault_count), 32'd0);
        iso_en = 1'b0;

        // Reset in ON, then saturate the fault counter
        do_reset();
        ramp_up(102);
        rst_n = 1'b0;
        tick("reset_in_on");
        check("reset_in_on_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pwr_req = 1'b1; fault_clr = 1'b0;
            set_bias(1'b0, 1'b0, 1'b0, 1'b0);
            tick("sat_ramp");
            rx_bias = 1'b1;
            tick("sat_fault");
            pwr_req = 1'b0; fault_clr = 1'b1; rx_bias = 1'b0;
            tick("sat_clear");
        end
        fault_clr = 1'b0;
        check("count_saturated", 32'(fault_count), 32'd255);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            pwr_req    = ($urandom_range(0, 19) != 0);
            iso_en     = ($urandom_range(0, 29) == 0);
            fault_clr  = ($urandom_range(0, 3) == 0);
            if (fault_clr && $urandom_range(0, 1) == 0) pwr_req = 1'b0;
            set_bias($urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
                     $urandom_range(0, 15) != 0, $urandom_range(0, 7) != 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serdesphy_ana_bias_monitor.md
SERDESPHY_ANA_BIAS_MONITOR -- requirements
Module: serdesphy_ana_bias_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 160: maximum RAMP cycles allowed for bias_ready to assert.
REQ-002 SHALL have parameter SETTLE_CYC, default 4: cycles that all biases must stay high before analog enables assert.
REQ-003 SHALL have port clk, input, 1: system clock; the only clock.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port pwr_req, input, 1: level request to power analog domains.
REQ-006 SHALL have port iso_en, input, 1: analog isolation; forces orderly shutdown.
REQ-007 SHALL have ports tx_bias, rx_bias, vco_bias, bias_ready, inputs, 1 each: status from the bias generator.
REQ-008 SHALL have port fault_clr, input, 1: clears a latched fault.
REQ-009 SHALL have port bias_en, output, 1: enable to the bias generator.
REQ-010 SHALL have ports tx_ana_en, rx_ana_en, pll_ana_en, outputs, 1 each: downstream analog enables.
REQ-011 SHALL have port pwr_ack, output, 1: power-good acknowledge for pwr_req.
REQ-012 SHALL have port bias_fault, output, 1: fault latched.
REQ-013 SHALL have port fault_code, output, 2: 0 none, 1 timeout, 2 order, 3 dropout.
REQ-014 SHALL have port fault_count, output, 8: saturating count of faults entered.
REQ-015 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-016 SHALL implement a Moore FSM with states OFF=0, RAMP=1, SETTLE=2, ON=3, and FAULT=4; all outputs are registered and decoded from the state register.
REQ-017 OFF SHALL hold all outputs low; pwr_req=1 with iso_en=0 SHALL go to RAMP and clear the timer.
REQ-018 RAMP SHALL hold bias_en=1 and increment an 8-bit timer each cycle.
REQ-019 RAMP exit priority SHALL be, highest first: (iso_en or !pwr_req) -> OFF; order violation -> FAULT(2); timer == TIMEOUT_CYC-1 -> FAULT(1); bias_ready with all three biases high -> SETTLE.
REQ-020 An order violation SHALL be rx_bias=1 while tx_bias=0, or vco_bias=1 while rx_bias=0, sampled in RAMP, SETTLE, or ON.
REQ-021 SETTLE SHALL hold bias_en=1 and count SETTLE_CYC cycles; any of bias_ready, tx_bias, rx_bias, or vco_bias low SHALL go to FAULT(3); count complete SHALL go to ON.
REQ-022 ON SHALL drive bias_en, tx_ana_en, rx_ana_en, pll_ana_en, and pwr_ack to 1.
REQ-023 ON SHALL go to OFF on iso_en or !pwr_req, and to FAULT(3) on any bias input dropping.
REQ-024 When shutdown and fault occur in the same cycle, shutdown SHALL win.
REQ-025 FAULT SHALL drive bias_en and all enables to 0, bias_fault=1, and hold fault_code.
REQ-026 FAULT SHALL exit to OFF only when fault_clr=1 and pwr_req=0; fault_clr with pwr_req=1 SHALL be ignored.
REQ-027 On the exit from FAULT, fault_code SHALL clear to 0; fault_code SHALL be 0 in every other state.
REQ-028 fault_count SHALL increment on each entry into FAULT and saturate at 255.
REQ-029 fault_clr outside FAULT SHALL have no effect.
REQ-030 The timer SHALL stop counting after the state exits RAMP, and SHALL restart from 0 on the next RAMP entry.
REQ-031 The SETTLE counter SHALL restart from 0 on each SETTLE entry.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state=OFF, all outputs 0, timers 0, fault_code=0, and fault_count=0, including from mid-RAMP, ON, or FAULT.
REQ-033 After rst_n returns high, the FSM SHALL leave OFF no earlier than the first edge with pwr_req=1.

Verification
REQ-034 Bench SHALL cover: pwr_req=1 with a bias model giving tx@1, rx@33, vco@65, ready@97 -> RAMP, then SETTLE, then ON 4 cycles later; pwr_ack=1 and all enables=1.
REQ-035 Bench SHALL cover: pwr_req=1 with bias_ready never asserting -> FAULT after 160 RAMP cycles; fault_code=1, bias_en=0, fault_count=1.
REQ-036 Bench SHALL cover: in ON, rx_bias forced low for 1 cycle -> FAULT with code 3; fault_clr with pwr_req=1 -> stays in FAULT; fault_clr with pwr_req=0 -> OFF, fault_code=0, fault_count remains 1.
REQ-037 Bench SHALL cover: in RAMP, vco_bias=1 while rx_bias=0 -> FAULT with code 2.
REQ-038 Bench SHALL cover: in SETTLE, iso_en and bias_ready drop in the same cycle -> OFF with no fault and fault_count unchanged.
REQ-039 Bench SHALL cover: rst_n=0 for 1 cycle while in ON -> next cycle state=0 and all outputs 0; 256 forced faults -> fault_count=255.
